// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: signal bundle between icache, fetch buffer and decode.
// FETCH_BUFFER_PERF_EN adds the fetch_bubble_cnt counter output.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef N_WAY
`define N_WAY 3
`endif
interface fetch_buffer_if #(
    parameter int N_WAY = `N_WAY,
    parameter int IB_DEPTH = 8
);
    localparam int CW = $clog2(N_WAY) + 1;
    localparam int OW = $clog2(IB_DEPTH) + 1;
    logic redirect_en;
    logic [`XLEN-1:0] redirect_pc;
    logic [N_WAY-1:0][`XLEN-1:0] Icache_data_out;
    logic [N_WAY-1:0][`XLEN-1:0] Icache_addr_out;
    logic [N_WAY-1:0] Icache_valid_out;
    logic [CW-1:0] dec_ready_count;
    logic [`XLEN-1:0] proc2Icache_addr;
    logic [CW-1:0] proc2Icache_count;
    logic [N_WAY-1:0][`XLEN-1:0] ib_inst_out;
    logic [N_WAY-1:0][`XLEN-1:0] ib_pc_out;
    logic [N_WAY-1:0] ib_valid_out;
    logic [OW-1:0] ib_occupancy;
`ifdef FETCH_BUFFER_PERF_EN
    logic [31:0] fetch_bubble_cnt;
`endif
    modport slave (
        input redirect_en, redirect_pc, Icache_data_out, Icache_addr_out, Icache_valid_out, dec_ready_count,
        output proc2Icache_addr, proc2Icache_count, ib_inst_out, ib_pc_out, ib_valid_out, ib_occupancy
`ifdef FETCH_BUFFER_PERF_EN
        , output fetch_bubble_cnt
`endif
    );
    modport master (
        output redirect_en, redirect_pc, Icache_data_out, Icache_addr_out, Icache_valid_out, dec_ready_count,
        input proc2Icache_addr, proc2Icache_count, ib_inst_out, ib_pc_out, ib_valid_out, ib_occupancy
`ifdef FETCH_BUFFER_PERF_EN
        , input fetch_bubble_cnt
`endif
    );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: fetch PC generator and in-order instruction buffer between icache and decode.
// Define FETCH_BUFFER_PERF_EN to add the saturating fetch_bubble_cnt counter.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef N_WAY
`define N_WAY 3
`endif
module fetch_buffer #(
    parameter int N_WAY = `N_WAY,
    parameter int IB_DEPTH = 8,
    parameter logic [`XLEN-1:0] RESET_PC = '0
) (
    input logic clock,
    input logic reset,
    fetch_buffer_if.slave bus
);
    localparam int PW = $clog2(IB_DEPTH);
    localparam int CW = $clog2(N_WAY) + 1;
    localparam int OW = PW + 1;
    logic [`XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [OW-1:0] occ_q, occ_d;
    logic squash_q, squash_d;
    logic [`XLEN-1:0] inst_mem [IB_DEPTH];
    logic [`XLEN-1:0] pc_mem [IB_DEPTH];
    logic [OW-1:0] space, ready, accept_n, deq_n;
    logic run;
    assign space = OW'(IB_DEPTH) - occ_q;
    assign ready = OW'(bus.dec_ready_count);
    assign deq_n = ready < occ_q ? ready : occ_q;
    assign bus.proc2Icache_addr = fetch_pc_q;
    assign bus.proc2Icache_count = space < OW'(N_WAY) ? CW'(space) : CW'(N_WAY);
    assign bus.ib_occupancy = occ_q;
    // Accept the longest in-order, address-matched prefix that still fits.
    always_comb begin
        accept_n = '0;
        run = !squash_q;
        for (int i = 0; i < N_WAY; i++) begin
            run = run && bus.Icache_valid_out[i] && OW'(i) < space &&
                  bus.Icache_addr_out[i] == fetch_pc_q + `XLEN'(4 * i);
            accept_n = accept_n + OW'(run);
        end
    end
    always_comb begin
        fetch_pc_d = bus.redirect_en ? bus.redirect_pc : fetch_pc_q + (`XLEN'(accept_n) << 2);
        head_d = bus.redirect_en ? '0 : head_q + PW'(deq_n);
        tail_d = bus.redirect_en ? '0 : tail_q + PW'(accept_n);
        occ_d = bus.redirect_en ? '0 : occ_q + accept_n - deq_n;
        squash_d = bus.redirect_en;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            head_q <= '0;
            tail_q <= '0;
            occ_q <= '0;
            squash_q <= 1'b1;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q <= occ_d;
            squash_q <= squash_d;
        end
    end
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_WAY; i++)
            if (!bus.redirect_en && OW'(i) < accept_n) begin
                inst_mem[tail_q + PW'(i)] <= bus.Icache_data_out[i];
                pc_mem[tail_q + PW'(i)] <= bus.Icache_addr_out[i];
            end
    end
    always_comb begin
        for (int i = 0; i < N_WAY; i++) begin
            bus.ib_inst_out[i] = inst_mem[head_q + PW'(i)];
            bus.ib_pc_out[i] = pc_mem[head_q + PW'(i)];
            bus.ib_valid_out[i] = OW'(i) < occ_q;
        end
    end
`ifdef FETCH_BUFFER_PERF_EN
    logic [31:0] bubble_q, bubble_d;
    always_comb
        bubble_d = bus.redirect_en ? '0 :
                   (accept_n == '0 && !squash_q && occ_q < OW'(IB_DEPTH) && bubble_q != '1) ? bubble_q + 32'd1 :
                   bubble_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) bubble_q <= '0;
        else bubble_q <= bubble_d;
    end
    assign bus.fetch_bubble_cnt = bubble_q;
`endif
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed and randomized checks of fetch_buffer against a queue-based model.
module tb_fetch_buffer;
    localparam int N = 3;
    localparam int D = 8;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;
    fetch_buffer_if #(.N_WAY(N), .IB_DEPTH(D)) bus ();
    fetch_buffer #(.N_WAY(N), .IB_DEPTH(D), .RESET_PC(32'h0)) dut (.clock(clock), .reset(reset), .bus(bus));
    int checks = 0;
    int errors = 0;
    logic [31:0] m_pc[$];
    logic [31:0] m_inst[$];
    logic [31:0] m_fpc = '0;
    bit m_squash = 1'b1;
    logic [31:0] m_bub = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lanes(input logic [N-1:0] v, input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            bus.Icache_valid_out[i] = v[i];
            bus.Icache_addr_out[i] = m_fpc + 32'(4 * i) + (m[i] ? 32'h0 : 32'h100);
            bus.Icache_data_out[i] = $urandom;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] vexp;
        int sz = m_pc.size();
        chk("req_addr", 64'(bus.proc2Icache_addr), 64'(m_fpc));
        chk("req_count", 64'(bus.proc2Icache_count), 64'((D - sz) < N ? D - sz : N));
        chk("occupancy", 64'(bus.ib_occupancy), 64'(sz));
        for (int i = 0; i < N; i++) vexp[i] = i < sz;
        chk("valid_mask", 64'(bus.ib_valid_out), 64'(vexp));
        for (int i = 0; i < N; i++)
            if (i < sz) begin
                chk("out_pc", 64'(bus.ib_pc_out[i]), 64'(m_pc[i]));
                chk("out_inst", 64'(bus.ib_inst_out[i]), 64'(m_inst[i]));
            end
`ifdef FETCH_BUFFER_PERF_EN
        chk("bubble_cnt", 64'(bus.fetch_bubble_cnt), 64'(m_bub));
`endif
    endtask

    task automatic model_update();
        int acc = 0;
        int room = D - m_pc.size();
        int dec = int'(bus.dec_ready_count);
        int deq = dec < m_pc.size() ? dec : m_pc.size();
        if (bus.redirect_en) begin
            m_pc.delete();
            m_inst.delete();
            m_fpc = bus.redirect_pc;
            m_squash = 1'b1;
            m_bub = '0;
            return;
        end
        if (!m_squash)
            while (acc < N && acc < room && bus.Icache_valid_out[acc] &&
                   bus.Icache_addr_out[acc] == m_fpc + 32'(4 * acc)) acc++;
        if (acc == 0 && !m_squash && room > 0 && m_bub != 32'hFFFF_FFFF) m_bub++;
        repeat (deq) begin
            void'(m_pc.pop_front());
            void'(m_inst.pop_front());
        end
        for (int i = 0; i < acc; i++) begin
            m_pc.push_back(bus.Icache_addr_out[i]);
            m_inst.push_back(bus.Icache_data_out[i]);
        end
        m_fpc += 32'(4 * acc);
        m_squash = 1'b0;
    endtask

    task automatic step();
        @(negedge clock);
        check_outputs();
        model_update();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_ready_count = '0;
        set_lanes('0, '1);
        #1 reset = 1'b1;
        #2;
        chk("rst_occupancy", 64'(bus.ib_occupancy), 64'd0);
        chk("rst_valid", 64'(bus.ib_valid_out), 64'd0);
        chk("rst_addr", 64'(bus.proc2Icache_addr), 64'h0);
        chk("rst_count", 64'(bus.proc2Icache_count), 64'd3);
        @(posedge clock);
        #1 reset = 1'b0;
        set_lanes('1, '1); step();
        chk("squash_drop", 64'(bus.ib_occupancy), 64'd0);
        set_lanes('1, '1); step();
        chk("first_occ", 64'(bus.ib_occupancy), 64'd3);
        chk("first_addr", 64'(bus.proc2Icache_addr), 64'hC);
        chk("first_pc0", 64'(bus.ib_pc_out[0]), 64'h0);
        chk("first_pc1", 64'(bus.ib_pc_out[1]), 64'h4);
        chk("first_pc2", 64'(bus.ib_pc_out[2]), 64'h8);
        set_lanes(3'b101, '1); step();
        chk("gap_addr", 64'(bus.proc2Icache_addr), 64'h10);
        chk("gap_occ", 64'(bus.ib_occupancy), 64'd4);
        set_lanes('1, '1); step();
        chk("occ7", 64'(bus.ib_occupancy), 64'd7);
        chk("count_at7", 64'(bus.proc2Icache_count), 64'd1);
        set_lanes('1, '1); step();
        chk("occ_full", 64'(bus.ib_occupancy), 64'd8);
        chk("count_full", 64'(bus.proc2Icache_count), 64'd0);
        bus.dec_ready_count = 3'd3; set_lanes('1, '1); step();
        chk("full_drain", 64'(bus.ib_occupancy), 64'd5);
        bus.dec_ready_count = 3'd0; set_lanes('1, '1); step();
        chk("refill", 64'(bus.ib_occupancy), 64'd8);
        bus.dec_ready_count = 3'd3; set_lanes('0, '1); step();
        chk("drain5", 64'(bus.ib_occupancy), 64'd5);
        bus.dec_ready_count = 3'd0; bus.redirect_en = 1'b1; bus.redirect_pc = 32'h200; step();
        chk("redir_occ", 64'(bus.ib_occupancy), 64'd0);
        chk("redir_addr", 64'(bus.proc2Icache_addr), 64'h200);
        bus.redirect_en = 1'b0; set_lanes(3'b001, '1); step();
        chk("redir_squash", 64'(bus.ib_occupancy), 64'd0);
        set_lanes(3'b001, '1); step();
        chk("redir_accept", 64'(bus.ib_occupancy), 64'd1);
        set_lanes(3'b001, '1); step();
`ifdef FETCH_BUFFER_PERF_EN
        repeat (4) begin set_lanes('1, '0); step(); end
        chk("bubble4", 64'(bus.fetch_bubble_cnt), 64'd4);
        bus.redirect_en = 1'b1; bus.redirect_pc = 32'h40; step();
        chk("bubble_clr", 64'(bus.fetch_bubble_cnt), 64'd0);
        bus.redirect_en = 1'b0;
`endif
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] v, m;
            bus.redirect_en = $urandom_range(0, 99) < 3;
            bus.redirect_pc = $urandom_range(0, 9) == 0 ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 1023) * 4);
            bus.dec_ready_count = 3'($urandom_range(0, N));
            for (int i = 0; i < N; i++) begin
                v[i] = $urandom_range(0, 9) < 8;
                m[i] = $urandom_range(0, 9) < 8;
            end
            set_lanes(v, m);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Fetch-stage PC generator and instruction buffer directly downstream of the instruction cache.
- Drives the cache request address and count each cycle, and accepts returned lanes that are in-order and address-matched.
- Holds accepted instructions in a circular FIFO and delivers up to N_WAY instructions per cycle, in program order, to decode.
- Handles redirects (branch or exception) by flushing and re-steering the PC.

Parameters:
- N_WAY, `N_WAY, lanes per cycle on the cache side and the decode side.
- IB_DEPTH, 8, buffer entries; power of 2 and >= N_WAY.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- redirect_en  in  1  flush and re-steer fetch
- redirect_pc  in  `XLEN  new fetch PC
- Icache_data_out  in  N_WAY x `XLEN  cache lane instructions
- Icache_addr_out  in  N_WAY x `XLEN  cache lane PCs
- Icache_valid_out  in  N_WAY  cache lane valids
- dec_ready_count  in  $clog2(N_WAY)+1  instructions decode accepts this cycle (0..N_WAY)
- proc2Icache_addr  out  `XLEN  fetch PC request
- proc2Icache_count  out  $clog2(N_WAY)+1  lanes requested
- ib_inst_out  out  N_WAY x `XLEN  instructions to decode, lane 0 oldest
- ib_pc_out  out  N_WAY x `XLEN  matching PCs
- ib_valid_out  out  N_WAY  contiguous-from-lane-0 valid mask
- ib_occupancy  out  $clog2(IB_DEPTH)+1  current entry count

Behaviour:
- State: fetch_pc, head, tail (mod IB_DEPTH), occupancy, squash flag. All are reset asynchronously on reset; otherwise they update on posedge clock.
- Reset values:
  - fetch_pc=RESET_PC, head=tail=occupancy=0, squash=1.
  - Resulting outputs: ib_valid_out=0, ib_occupancy=0, proc2Icache_addr=RESET_PC, proc2Icache_count=min(N_WAY,IB_DEPTH).
- Request (combinational):
  - proc2Icache_addr=fetch_pc.
  - proc2Icache_count=min(N_WAY, IB_DEPTH-occupancy); this is 0 when full.
- Cache responses arrive one cycle after the request. Acceptance is by address, not by timing.
- Acceptance:
  - accept_n is the largest k such that, for every lane i<k: Icache_valid_out[i]=1 and Icache_addr_out[i]==fetch_pc+4*i.
  - k is also clamped to IB_DEPTH-occupancy (pre-dequeue value).
  - A mismatch or invalid lane stops acceptance; later lanes are dropped even if valid.
- Enqueue: lanes 0..accept_n-1 are written at tail+i (mod IB_DEPTH); tail+=accept_n; fetch_pc+=4*accept_n.
- Dequeue:
  - deq_n=min(occupancy, dec_ready_count).
  - ib_inst_out[i]/ib_pc_out[i] present entry head+i (combinational); ib_valid_out[i]=(i<occupancy).
  - head+=deq_n.
  - Decode may only rely on lanes < dec_ready_count being consumed.
- occupancy_next=occupancy+accept_n-deq_n. Simultaneous enqueue and dequeue is legal. When full and draining, new lanes are accepted only in the following cycle (clamp uses pre-dequeue occupancy).
- Wrap-around: pointers are $clog2(IB_DEPTH) bits and wrap naturally; occupancy disambiguates full from empty.
- Redirect (highest priority, same edge):
  - head=tail=occupancy=0, fetch_pc=redirect_pc, squash=1; no enqueue or dequeue that cycle.
  - ib_valid_out is still driven from the pre-flush state in the redirect cycle; decode ignores it.
- Squash: in the cycle after a redirect or reset, accept_n is forced to 0. This kills stale in-flight responses that could alias the new PC. squash then clears to 0.
- Back-to-back redirects: the later one wins; squash remains set.
- PC arithmetic is modulo 2^`XLEN; wrap at 0xFFFFFFFC to 0 is not special-cased.

Optional Feature:
- Macro: FETCH_BUFFER_PERF_EN.
- Defined:
  - Adds output fetch_bubble_cnt (32 bits, reset 0).
  - Increments each cycle with accept_n==0, squash==0, redirect_en==0 and occupancy<IB_DEPTH; saturates at 0xFFFFFFFF.
  - Clears on redirect.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan (N_WAY=3, IB_DEPTH=8, RESET_PC=0):
- Reset release, cache returns valid lanes 0x0/0x4/0x8 at cycle 1 -> ignored (squash). Cycle 2 same lanes -> accept 3, fetch_pc=0xC, occupancy=3, ib_pc_out={0x0,0x4,0x8}.
- fetch_pc=0xC, lanes {0xC valid, 0x10 invalid, 0x14 valid} -> accept 1, fetch_pc=0x10; lane 0x14 dropped.
- Fill to occupancy=7 with dec_ready_count=0 -> proc2Icache_count=1; three matching lanes returned -> accept 1, occupancy=8, proc2Icache_count=0.
- Occupancy 8, dec_ready_count=3, three matching lanes returned -> deq 3, accept 0, occupancy=5. Next cycle accept 3 -> occupancy=8 (with dec_ready_count=0 that cycle). head and tail wrap correctly past index 7.
- Occupancy 5, redirect_en=1 with redirect_pc=0x200, cache returns lane 0x200 valid in the following cycle -> occupancy=0, proc2Icache_addr=0x200, response not accepted (squash). Accepted the cycle after.
- With FETCH_BUFFER_PERF_EN: 4 cycles of non-matching responses at occupancy 2 -> fetch_bubble_cnt=4; a redirect -> fetch_bubble_cnt=0.
